pipe_reg_sync_reset: RTL and testbench

PIPE_REG_SYNC_RESET -- requirements
Module: pipe_reg_sync_reset

---
 rtl/pipe_reg_sync_reset_pkg.sv | 17 +
 rtl/pipe_reg_sync_reset_dff.sv | 26 ++
 rtl/pipe_reg_sync_reset.sv | 93 +++++++++
 tb/tb_pipe_reg_sync_reset.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/pipe_reg_sync_reset_pkg.sv
// Shared helper for pipe_reg_sync_reset: ceiling log2 used to size the occupancy count.
package pipe_reg_sync_reset_pkg;

  // Returns at least 1 so a one-value range still gets a one-bit counter.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/pipe_reg_sync_reset_dff.sv
// Enabled register with synchronous active-high reset to a parameterised value.
module dff_en_sync_reset #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             sync_reset_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (sync_reset_i) begin
      q_q <= RESET_VAL;
    end else if (en_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/pipe_reg_sync_reset.sv
// Enabled pipeline register chain with per-stage valid flags, flush and a registered occupancy count.
module pipe_reg_sync_reset
  import pipe_reg_sync_reset_pkg::*;
#(
  parameter  int               WIDTH     = 8,
  parameter  int               DEPTH     = 4,
  parameter  logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int               OCC_W     = clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             sync_reset,
  input  logic             en,
  input  logic             flush,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  output logic [OCC_W-1:0] occupancy
);

  logic [DEPTH-1:0][WIDTH-1:0] stage_d;
  logic [DEPTH-1:0][WIDTH-1:0] stage_q;
  logic [DEPTH-1:0]            valid_d;
  logic [DEPTH-1:0]            valid_q;
  logic [OCC_W-1:0]            occ_d;
  logic [OCC_W-1:0]            occ_q;
  logic                        data_en;
  logic                        valid_clr;

  // Flush leaves data in place but drops the incoming word; it clears valids even when stalled.
  assign data_en   = en & ~flush;
  assign valid_clr = sync_reset | flush;

  // NOTE: every next-state variable gets a default before any loop or branch, so no latch is inferred.
  always_comb begin
    stage_d    = stage_q;
    valid_d    = valid_q;
    stage_d[0] = d;
    valid_d[0] = d_valid;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
      valid_d[i] = valid_q[i-1];
    end
  end

  // NOTE: data stages are real registers, not a RAM, so they can all take RESET_VAL in one edge.
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    dff_en_sync_reset #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_data (
      .clk          (clk),
      .sync_reset_i (sync_reset),
      .en_i         (data_en),
      .d_i          (stage_d[i]),
      .q_o          (stage_q[i])
    );

    dff_en_sync_reset #(
      .WIDTH     (1),
      .RESET_VAL (1'b0)
    ) u_valid (
      .clk          (clk),
      .sync_reset_i (valid_clr),
      .en_i         (en),
      .d_i          (valid_d[i]),
      .q_o          (valid_q[i])
    );
  end

  // Entering and leaving in the same edge cancel, so a full pipe stays at DEPTH.
  always_comb begin
    occ_d = occ_q;
    if (flush) begin
      occ_d = '0;
    end else if (en) begin
      occ_d = occ_q + OCC_W'(d_valid) - OCC_W'(valid_q[DEPTH-1]);
    end
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign q         = stage_q[DEPTH-1];
  assign q_valid   = valid_q[DEPTH-1];
  assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_reg_sync_reset.sv
// Self-checking bench: a DEPTH=4 and a DEPTH=1 build share stimulus and are compared to a queue model.
module tb_pipe_reg_sync_reset;

  localparam logic [7:0] RV = 8'hA5;

  typedef struct {
    logic [7:0] data;
    logic       valid;
  } ent_t;

  logic       clk = 1'b0;
  logic       sync_reset = 1'b0;
  logic       en = 1'b0;
  logic       flush = 1'b0;
  logic [7:0] d = 8'h00;
  logic       d_valid = 1'b0;

  logic [7:0] q0, q1;
  logic       qv0, qv1;
  logic [2:0] occ0;
  logic [0:0] occ1;

  int checks = 0;
  int failures = 0;

  // Model: each pipe is a queue of the last DEPTH accepted words, oldest at index 0.
  ent_t mq[2][$];
  int   dep[2] = '{4, 1};

  always #5 clk = ~clk;

  pipe_reg_sync_reset #(.WIDTH(8), .DEPTH(4), .RESET_VAL(RV)) u_dut4 (
    .clk(clk), .sync_reset(sync_reset), .en(en), .flush(flush), .d(d), .d_valid(d_valid),
    .q(q0), .q_valid(qv0), .occupancy(occ0)
  );

  pipe_reg_sync_reset #(.WIDTH(8), .DEPTH(1), .RESET_VAL(RV)) u_dut1 (
    .clk(clk), .sync_reset(sync_reset), .en(en), .flush(flush), .d(d), .d_valid(d_valid),
    .q(q1), .q_valid(qv1), .occupancy(occ1)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic model_edge(input logic sr, input logic e, input logic f,
                            input logic [7:0] dd, input logic dv);
    ent_t ent;
    for (int m = 0; m < 2; m++) begin
      if (sr) begin
        mq[m].delete();
      end else if (f) begin
        for (int i = 0; i < mq[m].size(); i++) begin
          ent = mq[m][i];
          ent.valid = 1'b0;
          mq[m][i] = ent;
        end
      end else if (e) begin
        ent.data = dd;
        ent.valid = dv;
        mq[m].push_back(ent);
        if (mq[m].size() > dep[m]) void'(mq[m].pop_front());
      end
    end
  endtask

  task automatic compare_all(input string tag);
    logic [7:0] eq;
    logic       ev;
    int         eocc;
    for (int m = 0; m < 2; m++) begin
      eocc = 0;
      foreach (mq[m][i]) if (mq[m][i].valid) eocc++;
      if (mq[m].size() == dep[m]) begin
        eq = mq[m][0].data;
        ev = mq[m][0].valid;
      end else begin
        eq = RV;
        ev = 1'b0;
      end
      if (m == 0) begin
        check($sformatf("%s.d4.q", tag), 32'(q0), 32'(eq));
        check($sformatf("%s.d4.q_valid", tag), 32'(qv0), 32'(ev));
        check($sformatf("%s.d4.occ", tag), 32'(occ0), 32'(eocc));
      end else begin
        check($sformatf("%s.d1.q", tag), 32'(q1), 32'(eq));
        check($sformatf("%s.d1.q_valid", tag), 32'(qv1), 32'(ev));
        check($sformatf("%s.d1.occ", tag), 32'(occ1), 32'(eocc));
      end
    end
  endtask

  // Drive one edge's inputs, clock, update the model and compare 1 time unit after the edge.
  task automatic step(input string tag, input logic sr, input logic e, input logic f,
                      input logic [7:0] dd, input logic dv);
    sync_reset = sr;
    en = e;
    flush = f;
    d = dd;
    d_valid = dv;
    @(posedge clk);
    model_edge(sr, e, f, dd, dv);
    #1;
    compare_all(tag);
  endtask

  initial begin
    // Reset with every competing control high must behave like a plain reset.
    step("rst_prio", 1, 1, 1, 8'h77, 1);
    check("rst_prio.q_is_rv", 32'(q0), 32'(RV));
    step("rst", 1, 0, 0, 8'h00, 0);

    // Streaming ramp: first word appears on the 4th enabled edge (1st for DEPTH=1).
    for (int i = 1; i <= 7; i++) step($sformatf("stream%0d", i), 0, 1, 0, 8'(i), 1);
    check("stream.full_occ", 32'(occ0), 32'd4);

    // Stall with two entries in flight, then resume.
    step("stall_rst", 1, 0, 0, 8'h00, 0);
    step("stall_fill1", 0, 1, 0, 8'h11, 1);
    step("stall_fill2", 0, 1, 0, 8'h22, 1);
    for (int i = 0; i < 5; i++) step($sformatf("stall_hold%0d", i), 0, 0, 0, 8'($urandom), 1'($urandom));
    step("stall_resume1", 0, 1, 0, 8'h33, 0);
    check("stall_resume1.not_yet", 32'(qv0), 32'd0);
    step("stall_resume2", 0, 1, 0, 8'h44, 0);
    check("stall_resume2.out", 32'(q0), 32'h11);

    // Flush on the same edge as an enabled 8'hFF; FF must never emerge.
    for (int i = 0; i < 4; i++) step($sformatf("flush_fill%0d", i), 0, 1, 0, 8'h50 + 8'(i), 1);
    step("flush", 0, 1, 1, 8'hFF, 1);
    check("flush.occ_zero", 32'(occ0), 32'd0);
    for (int i = 0; i < 5; i++) begin
      step($sformatf("flush_drain%0d", i), 0, 1, 0, 8'h60 + 8'(i), 0);
      check($sformatf("flush_drain%0d.no_ff", i), 32'(q0 == 8'hFF), 32'd0);
    end

    // Alternating bubbles: steady-state occupancy of 2 in the deep pipe.
    for (int i = 0; i < 12; i++) step($sformatf("bubble%0d", i), 0, 1, 0, 8'h80 + 8'(i), 1'(~i[0]));
    check("bubble.steady_occ", 32'(occ0), 32'd2);

    // Reset mid-stream discards in-flight words.
    step("mid_rst", 1, 1, 0, 8'hC0, 1);
    for (int i = 0; i < 4; i++) step($sformatf("post_rst%0d", i), 0, 1, 0, 8'hD0 + 8'(i), 1);

    // Random traffic, mostly enabled, with occasional flush and reset.
    for (int i = 0; i < 400; i++) begin
      step($sformatf("rand%0d", i),
           1'($urandom_range(0, 99) < 3),
           1'($urandom_range(0, 99) < 75),
           1'($urandom_range(0, 99) < 6),
           8'($urandom),
           1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
